// File: rtl/mem_bus_arbiter_if.sv
// Word-addressed memory bus bundle: command/data from a master, readdata/waitrequest back from a slave.
interface mem_bus_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned BW = DW / 8;

    logic [AW-1:0] addr;
    logic [DW-1:0] writedata;
    logic [BW-1:0] byteenable;
    logic          read;
    logic          write;
    logic [DW-1:0] readdata;
    logic          waitrequest;

    modport master (
        output addr, writedata, byteenable, read, write,
        input  readdata, waitrequest
    );

    modport slave (
        input  addr, writedata, byteenable, read, write,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the memory bus.
// Optional slave-stall abort is built when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic       Clock,
    input  logic       Resetn,
    mem_bus_if.slave   m0,
    mem_bus_if.slave   m1,
    mem_bus_if.master  s,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int unsigned BW = DW / 8;

    // State encoding doubles as the one-hot grant vector
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last;        // 0 = M0 granted last, 1 = M1
    logic          last_nxt;
    logic          req0;
    logic          req1;
    logic          tmo_limit;

    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wdata;
    logic [BW-1:0] mux_be;
    logic          mux_read;
    logic          mux_write;
    logic          wait0;
    logic          wait1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // State and fairness pointer
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Arbitration, command routing and completion
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        mux_addr  = '0;
        mux_wdata = '0;
        mux_be    = '0;
        mux_read  = 1'b0;
        mux_write = 1'b0;
        wait0     = 1'b1;
        wait1     = 1'b1;
        rdata0    = s.readdata;
        rdata1    = s.readdata;

        unique case (state)
            IDLE: begin
                if (req0 && (!req1 || last)) begin
                    state_nxt = G0;
                    last_nxt  = 1'b0;
                end else if (req1) begin
                    state_nxt = G1;
                    last_nxt  = 1'b1;
                end
            end

            G0: begin
                mux_addr  = m0.addr;
                mux_wdata = m0.writedata;
                mux_be    = m0.byteenable;
                mux_write = m0.write;
                mux_read  = m0.read & ~m0.write;
                wait0     = s.waitrequest;
                if (!req0 || !s.waitrequest) begin
                    state_nxt = IDLE;
                end else if (tmo_limit) begin
                    wait0     = 1'b0;
                    rdata0    = '0;
                    state_nxt = IDLE;
                end
            end

            G1: begin
                mux_addr  = m1.addr;
                mux_wdata = m1.writedata;
                mux_be    = m1.byteenable;
                mux_write = m1.write;
                mux_read  = m1.read & ~m1.write;
                wait1     = s.waitrequest;
                if (!req1 || !s.waitrequest) begin
                    state_nxt = IDLE;
                end else if (tmo_limit) begin
                    wait1     = 1'b0;
                    rdata1    = '0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign s.addr         = mux_addr;
    assign s.writedata    = mux_wdata;
    assign s.byteenable   = mux_be;
    assign s.read         = mux_read;
    assign s.write        = mux_write;
    assign m0.waitrequest = wait0;
    assign m1.waitrequest = wait1;
    assign m0.readdata    = rdata0;
    assign m1.readdata    = rdata1;
    assign grant          = 2'(state);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic          tmo_fire;

    // Limit is reached on the TIMEOUT-th consecutive stalled cycle of a grant
    assign tmo_limit = s.waitrequest && (wait_cnt == CW'(TIMEOUT - 1));
    assign tmo_fire  = tmo_limit && (((state == G0) && req0) || ((state == G1) && req1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (s.waitrequest) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    assign tmo_limit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised scoreboard bench for mem_bus_arbiter: two master drivers, a stalling slave and a rule-based monitor.
module tb_mem_bus_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = 4;
    localparam int unsigned TMO  = 4;
    localparam int          NTX  = 40;
    localparam int          MAXW = 200;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [1:0] grant;
    logic       timeout_err;

    mem_bus_if #(.AW(AW), .DW(DW)) m0_bus ();
    mem_bus_if #(.AW(AW), .DW(DW)) m1_bus ();
    mem_bus_if #(.AW(AW), .DW(DW)) s_bus ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t exp_q0[$];
    txn_t exp_q1[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    int   swait_left;

    // Slave memory contents as a fixed function of the address
    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hCAFE_0001;
    endfunction

    assign s_bus.readdata = rd_of(s_bus.addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int id, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
        if (id == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.addr = a;
            m0_bus.writedata = wd; m0_bus.byteenable = be;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.addr = a;
            m1_bus.writedata = wd; m1_bus.byteenable = be;
        end
    endtask

    function automatic logic wait_of(input int id);
        return (id == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
    endfunction

    // One master: issue NTX transactions, hold each until accepted, occasionally abandon one mid-grant
    task automatic run_master(input int id);
        txn_t t;
        int   op;
        int   gap;
        int   wc;
        bit   done;
        for (int n = 0; n < NTX; n++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge Clock);
                #1;
            end
            op      = $urandom_range(0, 3);
            t.is_wr = (op >= 2);
            t.addr  = 32'($urandom) & 32'h0000_FFFC;
            t.wdata = 32'($urandom);
            t.be    = 4'($urandom_range(1, 15));
            t.rdata = rd_of(t.addr);
            if (id == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
            drive(id, (op != 2), t.is_wr, t.addr, t.wdata, t.be);
            wc   = 0;
            done = 1'b0;
            while (!done && wc < MAXW) begin
                @(negedge Clock);
                if (wait_of(id) == 1'b0) begin
                    done = 1'b1;
                end else if (grant == ((id == 0) ? 2'b01 : 2'b10) && $urandom_range(0, 15) == 0) begin
                    done = 1'b1;
                    if (id == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
                end
                wc++;
                @(posedge Clock);
                #1;
            end
            chk($sformatf("master%0d_accepted", id), 32'(done), 32'd1);
            drive(id, 1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    // Slave: random 0..6 stall cycles per transfer
    initial begin
        logic st;
        logic wq;
        swait_left = 2;
        s_bus.waitrequest = 1'b1;
        forever begin
            @(negedge Clock);
            st = s_bus.read | s_bus.write;
            wq = s_bus.waitrequest;
            @(posedge Clock);
            #1;
            if (st) begin
                if (!wq) swait_left = $urandom_range(0, 6);
                else if (swait_left > 0) swait_left--;
            end
            s_bus.waitrequest = (swait_left != 0);
        end
    end

    // Monitor state: previous-cycle view plus reference arbitration history
    logic [1:0]    prev_g;
    logic          prev_r0, prev_r1, prev_done;
    logic          last_m;
    bit            err_m;
    int            wcnt_m;
    logic          r0, r1, oreq, exp_w, hit, o_rd, o_wr, n_wait, o_wait, have;
    logic [1:0]    exp_g;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd, n_rdd, o_rdd;
    logic [BW-1:0] o_be;
    txn_t          mt;

    always @(negedge Clock) begin
        if (mon_en) begin
            r0 = m0_bus.read | m0_bus.write;
            r1 = m1_bus.read | m1_bus.write;
            if (prev_g == 2'b00) begin
                if (prev_r0 && prev_r1) exp_g = last_m ? 2'b01 : 2'b10;
                else if (prev_r0)       exp_g = 2'b01;
                else if (prev_r1)       exp_g = 2'b10;
                else                    exp_g = 2'b00;
                if (exp_g != 2'b00) begin
                    last_m = exp_g[1];
                    wcnt_m = 0;
                end
            end else begin
                exp_g = prev_done ? 2'b00 : prev_g;
            end
            chk("grant", 32'(grant), 32'(exp_g));
            chk("timeout_err", 32'(timeout_err), 32'(err_m));
            prev_done = 1'b0;
            if (exp_g == 2'b00) begin
                chk("idle_s_read", 32'(s_bus.read), 0);
                chk("idle_s_write", 32'(s_bus.write), 0);
                chk("idle_s_addr", s_bus.addr, 0);
                chk("idle_s_wdata", s_bus.writedata, 0);
                chk("idle_s_be", 32'(s_bus.byteenable), 0);
                chk("idle_m0_wait", 32'(m0_bus.waitrequest), 1);
                chk("idle_m1_wait", 32'(m1_bus.waitrequest), 1);
                chk("idle_m0_rdata", m0_bus.readdata, s_bus.readdata);
            end else begin
                if (exp_g[0]) begin
                    oreq = r0; o_addr = m0_bus.addr; o_wd = m0_bus.writedata; o_be = m0_bus.byteenable;
                    o_rd = m0_bus.read; o_wr = m0_bus.write; o_wait = m0_bus.waitrequest;
                    o_rdd = m0_bus.readdata; n_wait = m1_bus.waitrequest; n_rdd = m1_bus.readdata;
                end else begin
                    oreq = r1; o_addr = m1_bus.addr; o_wd = m1_bus.writedata; o_be = m1_bus.byteenable;
                    o_rd = m1_bus.read; o_wr = m1_bus.write; o_wait = m1_bus.waitrequest;
                    o_rdd = m1_bus.readdata; n_wait = m0_bus.waitrequest; n_rdd = m0_bus.readdata;
                end
                hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
                hit = oreq && s_bus.waitrequest && (wcnt_m == int'(TMO) - 1);
`endif
                exp_w = hit ? 1'b0 : s_bus.waitrequest;
                chk("s_addr", s_bus.addr, o_addr);
                chk("s_wdata", s_bus.writedata, o_wd);
                chk("s_be", 32'(s_bus.byteenable), 32'(o_be));
                chk("s_write", 32'(s_bus.write), 32'(o_wr));
                chk("s_read", 32'(s_bus.read), 32'(o_rd & ~o_wr));
                chk("owner_wait", 32'(o_wait), 32'(exp_w));
                chk("other_wait", 32'(n_wait), 1);
                chk("other_rdata", n_rdd, s_bus.readdata);
                if (oreq && !exp_w) begin
                    have = 1'b0;
                    if (exp_g[0] && exp_q0.size() > 0) begin mt = exp_q0.pop_front(); have = 1'b1; end
                    if (exp_g[1] && exp_q1.size() > 0) begin mt = exp_q1.pop_front(); have = 1'b1; end
                    chk("sb_entry_present", 32'(have), 1);
                    if (have) begin
                        chk("sb_kind", 32'(s_bus.write), 32'(mt.is_wr));
                        chk("sb_addr", s_bus.addr, mt.addr);
                        if (mt.is_wr) begin
                            chk("sb_wdata", s_bus.writedata, mt.wdata);
                            chk("sb_be", 32'(s_bus.byteenable), 32'(mt.be));
                        end else begin
                            chk("sb_rdata", o_rdd, hit ? 32'd0 : mt.rdata);
                        end
                    end
                    if (hit) err_m = 1'b1;
                end
                prev_done = !oreq || !exp_w;
                if (s_bus.waitrequest) wcnt_m++;
            end
            prev_g  = exp_g;
            prev_r0 = r0;
            prev_r1 = r1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Resetn = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0000_0100, '0, 4'hF);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_read", 32'(s_bus.read), 0);
        chk("rst_m0_wait", 32'(m0_bus.waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_bus.waitrequest), 1);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        Resetn = 1'b1;
        @(negedge Clock);
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_s_read", 32'(s_bus.read), 1);
        chk("first_s_addr", s_bus.addr, 32'h0000_0100);
        @(posedge Clock);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge Clock);
        #1;
        prev_g = 2'b00; prev_r0 = 1'b0; prev_r1 = 1'b0; prev_done = 1'b0;
        last_m = 1'b0; err_m = 1'b0; wcnt_m = 0;
        mon_en = 1'b1;
        fork
            run_master(0);
            run_master(1);
        join
        @(posedge Clock);
        #1;
        mon_en = 1'b0;
        // Asynchronous reset in the middle of an M1 write
        drive(1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
        for (int k = 0; k < 10 && grant != 2'b10; k++) @(negedge Clock);
        chk("midrst_pre_grant", 32'(grant), 32'h2);
        #2;
        Resetn = 1'b0;
        #1;
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_s_write", 32'(s_bus.write), 0);
        chk("midrst_s_addr", s_bus.addr, 0);
        chk("midrst_m1_wait", 32'(m1_bus.waitrequest), 1);
        chk("midrst_timeout_err", 32'(timeout_err), 0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge Clock);
        Resetn = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
